evt_dgl_irq: RTL and testbench

EVT_DGL_IRQ -- requirements
Module: evt_dgl_irq

---
 rtl/evt_dgl_irq.sv | 195 +++++++++++++++++++
 tb/tb_evt_dgl_irq.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/evt_dgl_irq.sv
// -----------------------------------------------------------------------------
// evt_dgl_irq
//
// Event deglitcher and interrupt pulse generator for analog fault flags.
// Each raw flag is synchronised, deglitched by a per-channel programmable
// count and latched into a sticky flag register. Any unmasked rising event
// produces a fixed-length active-low pulse on intb. Events that arrive while a
// pulse (or its trailing gap) is in progress are remembered in int_pend and
// replayed as exactly one further pulse.
//
// Ports
//   main_clk20m  in   single clock, all flops on its rising edge
//   xpor         in   asynchronous active-low reset
//   evt_raw      in   [NCH]       raw fault flags, asynchronous, active high
//   dg_time      in   [NCH*CNTW]  per-channel deglitch count D
//   evt_mask     in   [NCH]       1 = channel does not generate interrupts
//   clr_req      in   [NCH]       write-1-to-clear strobes for evt_flg
//   evt_sta      out  [NCH]       deglitched real-time status
//   evt_flg      out  [NCH]       sticky event flags
//   intb         out              active-low interrupt pulse (registered)
//   int_pend     out              an unmasked event awaits its own pulse
// -----------------------------------------------------------------------------
module evt_dgl_irq #(
    parameter int NCH       = 8,
    parameter int CNTW      = 8,
    parameter int PULSE_LEN = 2000,
    parameter int GAP_LEN   = 20
) (
    input  logic                main_clk20m,
    input  logic                xpor,
    input  logic [NCH-1:0]      evt_raw,
    input  logic [NCH*CNTW-1:0] dg_time,
    input  logic [NCH-1:0]      evt_mask,
    input  logic [NCH-1:0]      clr_req,
    output logic [NCH-1:0]      evt_sta,
    output logic [NCH-1:0]      evt_flg,
    output logic                intb,
    output logic                int_pend
);

    localparam int MAXL = (PULSE_LEN > GAP_LEN) ? PULSE_LEN : GAP_LEN;
    localparam int PCW  = (MAXL > 1) ? $clog2(MAXL) : 1;
    localparam logic [PCW-1:0] PULSE_LAST = PCW'(PULSE_LEN - 1);
    localparam logic [PCW-1:0] GAP_LAST   = PCW'(GAP_LEN - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PULSE = 2'd1,
        GAP   = 2'd2
    } state_t;

    // ---------------------------------------------------------------------
    // Synchroniser and per-channel deglitch
    // ---------------------------------------------------------------------
    logic [NCH-1:0]  sync1_q;
    logic [NCH-1:0]  sync2_q;
    logic [NCH-1:0]  sta_q;
    logic [NCH-1:0]  sta_d;
    logic [NCH-1:0]  flg_q;
    logic [NCH-1:0]  flg_d;
    logic [NCH-1:0]  hit;
    logic [NCH-1:0]  rise;
    logic [CNTW-1:0] cnt_q [NCH];
    logic [CNTW-1:0] cnt_d [NCH];

    genvar gi;
    generate
        for (gi = 0; gi < NCH; gi++) begin : g_ch
            logic [CNTW-1:0] d_w;
            logic            differ;

            assign d_w    = dg_time[gi*CNTW +: CNTW];
            assign differ = sync2_q[gi] ^ sta_q[gi];
            // ">=" rather than "==" so a dg_time lowered below the running
            // count still terminates the count instead of letting it wrap.
            assign hit[gi]   = differ & (cnt_q[gi] >= d_w);
            assign rise[gi]  = hit[gi] & sync2_q[gi];
            assign sta_d[gi] = hit[gi] ? sync2_q[gi] : sta_q[gi];
            assign cnt_d[gi] = (!differ || hit[gi]) ? '0 : cnt_q[gi] + CNTW'(1);
            // Set has priority over clear so a rise is never swallowed.
            assign flg_d[gi] = rise[gi] | (flg_q[gi] & ~clr_req[gi]);
        end
    endgenerate

    always_ff @(posedge main_clk20m or negedge xpor) begin
        if (!xpor) begin
            sync1_q <= '0;
            sync2_q <= '0;
            sta_q   <= '0;
            flg_q   <= '0;
            for (int i = 0; i < NCH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            sync1_q <= evt_raw;
            sync2_q <= sync1_q;
            sta_q   <= sta_d;
            flg_q   <= flg_d;
            for (int i = 0; i < NCH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign evt_sta = sta_q;
    assign evt_flg = flg_q;

    // ---------------------------------------------------------------------
    // Interrupt pulse FSM
    // ---------------------------------------------------------------------
    logic           new_evt;
    state_t         state_q;
    state_t         state_d;
    logic [PCW-1:0] pcnt_q;
    logic [PCW-1:0] pcnt_d;
    logic           pend_q;
    logic           pend_d;
    logic           intb_q;
    logic           intb_d;

    assign new_evt = |(rise & ~evt_mask);

    // State register
    always_ff @(posedge main_clk20m or negedge xpor) begin
        if (!xpor) begin
            state_q <= IDLE;
            pcnt_q  <= '0;
            pend_q  <= 1'b0;
            intb_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            pcnt_q  <= pcnt_d;
            pend_q  <= pend_d;
            intb_q  <= intb_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        pcnt_d  = pcnt_q;
        pend_d  = pend_q;
        case (state_q)
            IDLE: begin
                if (new_evt) begin
                    state_d = PULSE;
                    pcnt_d  = '0;
                end
            end
            PULSE: begin
                if (new_evt) begin
                    pend_d = 1'b1;
                end
                if (pcnt_q == PULSE_LAST) begin
                    state_d = GAP;
                    pcnt_d  = '0;
                end else begin
                    pcnt_d = pcnt_q + PCW'(1);
                end
            end
            GAP: begin
                if (pcnt_q == GAP_LAST) begin
                    pcnt_d = '0;
                    // An event landing on the final gap cycle with nothing
                    // pending is served by this next pulse directly; if one
                    // was already pending it re-arms int_pend instead.
                    if (pend_q || new_evt) begin
                        state_d = PULSE;
                        pend_d  = pend_q & new_evt;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    pcnt_d = pcnt_q + PCW'(1);
                    if (new_evt) begin
                        pend_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                pcnt_d  = '0;
            end
        endcase
    end

    // Output logic: intb is registered, so decode it from the next state.
    always_comb begin
        intb_d = (state_d != PULSE);
    end

    assign intb     = intb_q;
    assign int_pend = pend_q;

endmodule

// File: tb/tb_evt_dgl_irq.sv
// -----------------------------------------------------------------------------
// tb_evt_dgl_irq
//
// Directed bench for evt_dgl_irq with default parameters (8 channels, 8-bit
// deglitch counters, 2000-clock pulse, 20-clock gap). Inputs change on the
// falling edge and outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_evt_dgl_irq;

    localparam int NCH  = 8;
    localparam int CNTW = 8;

    logic                clk;
    logic                xpor;
    logic [NCH-1:0]      evt_raw;
    logic [NCH*CNTW-1:0] dg_time;
    logic [NCH-1:0]      evt_mask;
    logic [NCH-1:0]      clr_req;
    logic [NCH-1:0]      evt_sta;
    logic [NCH-1:0]      evt_flg;
    logic                intb;
    logic                int_pend;

    int total;
    int bad;

    evt_dgl_irq #(
        .NCH      (NCH),
        .CNTW     (CNTW),
        .PULSE_LEN(2000),
        .GAP_LEN  (20)
    ) dut (
        .main_clk20m(clk),
        .xpor       (xpor),
        .evt_raw    (evt_raw),
        .dg_time    (dg_time),
        .evt_mask   (evt_mask),
        .clr_req    (clr_req),
        .evt_sta    (evt_sta),
        .evt_flg    (evt_flg),
        .intb       (intb),
        .int_pend   (int_pend)
    );

    initial clk = 1'b0;
    always #25 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end else begin
            $display("ok   %s: %0h", tag, obs);
        end
    endtask

    // n rising edges, then park on the following falling edge
    task automatic edges(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic measure_low(output int n);
        n = 0;
        while (intb == 1'b0 && n < 3000) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic measure_high(output int n);
        n = 0;
        while (intb == 1'b1 && n < 200) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic set_dg_all(input logic [7:0] d);
        for (int i = 0; i < NCH; i++) begin
            dg_time[i*CNTW +: CNTW] = d;
        end
    endtask

    int n;
    int lows;

    initial begin
        total    = 0;
        bad      = 0;
        xpor     = 1'b0;
        evt_raw  = '0;
        evt_mask = '0;
        clr_req  = '0;
        dg_time  = '0;
        set_dg_all(8'd5);

        // ---------------- reset state ----------------
        @(negedge clk);
        @(negedge clk);
        chk("rst_sta", 32'(evt_sta), 32'h0);
        chk("rst_flg", 32'(evt_flg), 32'h0);
        chk("rst_intb", 32'(intb), 32'h1);
        chk("rst_pend", 32'(int_pend), 32'h0);
        xpor = 1'b1;
        edges(2);

        // ---------------- deglitch D=5, 7-clock high ----------------
        evt_raw[0] = 1'b1;
        edges(7);
        chk("dg5_e7_sta", 32'(evt_sta[0]), 32'h0);
        evt_raw[0] = 1'b0;
        edges(1);
        chk("dg5_e8_sta", 32'(evt_sta[0]), 32'h1);
        chk("dg5_e8_flg", 32'(evt_flg[0]), 32'h1);
        chk("dg5_e8_intb", 32'(intb), 32'h0);
        measure_low(n);
        chk("dg5_pulse_len", 32'(n), 32'd2000);
        chk("dg5_fall_sta", 32'(evt_sta[0]), 32'h0);
        chk("dg5_flg_kept", 32'(evt_flg[0]), 32'h1);
        edges(30);
        clr_req = 8'h01;
        edges(1);
        clr_req = 8'h00;
        chk("clr0_flg", 32'(evt_flg), 32'h0);

        // 5-clock glitch on ch1 is rejected
        evt_raw[1] = 1'b1;
        edges(5);
        evt_raw[1] = 1'b0;
        edges(20);
        chk("glitch_sta", 32'(evt_sta), 32'h0);
        chk("glitch_flg", 32'(evt_flg), 32'h0);
        chk("glitch_intb", 32'(intb), 32'h1);

        // ---------------- boundaries D=0 / D=255 (masked) ----------------
        evt_mask = 8'h30;
        dg_time[4*CNTW +: CNTW] = 8'd0;
        dg_time[5*CNTW +: CNTW] = 8'd255;
        evt_raw[4] = 1'b1;
        edges(2);
        chk("d0_rise_e2", 32'(evt_sta[4]), 32'h0);
        edges(1);
        chk("d0_rise_e3", 32'(evt_sta[4]), 32'h1);
        evt_raw[5] = 1'b1;
        edges(257);
        chk("d255_rise_e257", 32'(evt_sta[5]), 32'h0);
        edges(1);
        chk("d255_rise_e258", 32'(evt_sta[5]), 32'h1);
        evt_raw[4] = 1'b0;
        edges(2);
        chk("d0_fall_e2", 32'(evt_sta[4]), 32'h1);
        edges(1);
        chk("d0_fall_e3", 32'(evt_sta[4]), 32'h0);
        evt_raw[5] = 1'b0;
        edges(257);
        chk("d255_fall_e257", 32'(evt_sta[5]), 32'h1);
        edges(1);
        chk("d255_fall_e258", 32'(evt_sta[5]), 32'h0);
        chk("bnd_flg", 32'(evt_flg), 32'h30);
        chk("bnd_masked_intb", 32'(intb), 32'h1);
        clr_req = 8'h30;
        edges(1);
        clr_req = 8'h00;
        chk("bnd_clr_flg", 32'(evt_flg), 32'h0);

        // ---------------- set/clear collision on ch2 ----------------
        evt_mask = 8'h00;
        set_dg_all(8'd5);
        evt_raw[2] = 1'b1;
        edges(7);
        clr_req = 8'h04;
        edges(1);
        chk("coll_set_wins", 32'(evt_flg[2]), 32'h1);
        chk("coll_sta", 32'(evt_sta[2]), 32'h1);
        chk("coll_intb", 32'(intb), 32'h0);
        edges(1);
        clr_req = 8'h00;
        chk("coll_clr_later", 32'(evt_flg[2]), 32'h0);

        // ---------------- back-to-back: ch3 rises 100 clocks in ----------------
        edges(90);
        evt_raw[3] = 1'b1;
        edges(8);
        chk("b2b_sta3", 32'(evt_sta[3]), 32'h1);
        chk("b2b_pend", 32'(int_pend), 32'h1);
        chk("b2b_intb_low", 32'(intb), 32'h0);
        measure_low(n);
        chk("b2b_rest_of_pulse", 32'(n), 32'd1901);
        measure_high(n);
        chk("b2b_gap_len", 32'(n), 32'd20);
        chk("b2b_pend_clr", 32'(int_pend), 32'h0);
        measure_low(n);
        chk("b2b_pulse2_len", 32'(n), 32'd2000);
        chk("b2b_pend_after", 32'(int_pend), 32'h0);

        // ---------------- mask test ----------------
        edges(30);
        evt_mask = 8'h01;
        evt_raw[0] = 1'b1;
        edges(8);
        chk("mask_flg0", 32'(evt_flg[0]), 32'h1);
        chk("mask_sta0", 32'(evt_sta[0]), 32'h1);
        lows = 0;
        for (int i = 0; i < 30; i++) begin
            if (intb == 1'b0) lows++;
            @(negedge clk);
        end
        chk("mask_no_pulse", 32'(lows), 32'd0);
        chk("mask_no_pend", 32'(int_pend), 32'h0);
        evt_raw[1] = 1'b1;
        edges(8);
        chk("unmask_sta1", 32'(evt_sta[1]), 32'h1);
        chk("unmask_intb", 32'(intb), 32'h0);
        evt_mask = 8'hFF;
        measure_low(n);
        chk("mask_mid_pulse_len", 32'(n), 32'd2000);

        // ---------------- reset mid-pulse ----------------
        edges(30);
        evt_mask = 8'h00;
        evt_raw[6] = 1'b1;
        edges(8);
        chk("rstp_intb_low", 32'(intb), 32'h0);
        edges(499);
        #5;
        xpor = 1'b0;
        #1;
        chk("rstp_intb_async", 32'(intb), 32'h1);
        chk("rstp_sta", 32'(evt_sta), 32'h0);
        chk("rstp_flg", 32'(evt_flg), 32'h0);
        chk("rstp_pend", 32'(int_pend), 32'h0);
        @(negedge clk);
        edges(2);
        xpor = 1'b1;
        edges(7);
        chk("rel_e7_intb", 32'(intb), 32'h1);
        chk("rel_e7_sta", 32'(evt_sta), 32'h0);
        edges(1);
        chk("rel_e8_sta", 32'(evt_sta), 32'h4F);
        chk("rel_e8_flg", 32'(evt_flg), 32'h4F);
        chk("rel_e8_intb", 32'(intb), 32'h0);
        measure_low(n);
        chk("rel_pulse_len", 32'(n), 32'd2000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
